// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter and its byte-merge helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

  localparam int DW_DEF = 32;
  localparam int AW_DEF = 32;

  localparam logic [3:0] BE_FULL = 4'hF;
  localparam logic [3:0] BE_NONE = 4'h0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_byte_merge.sv
// Byte-lane merge: each lane takes the new byte where be is set, else the old byte.
// Latency: purely combinational.
// Backpressure: none; a pure function of its inputs.
module dmem_byte_merge
  import dmem_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0]   old_word,
  input  logic [DW-1:0]   new_word,
  input  logic [DW/8-1:0] be,
  output logic [DW-1:0]   merged
);

  // Select each byte lane independently from the old or new word.
  always_comb begin
    merged = old_word;
    for (int i = 0; i < DW/8; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one word-wide data memory between CPU (port 0) and loader (port 1).
// Latency: ack 2 cycles after the grant-sampling edge for reads/full/empty writes, 3 for partial writes.
// Backpressure: requesters hold req until their ack; a port is ignored during its own ack cycle.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic [3:0]    be0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic [3:0]    be1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          mem_write,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_write_data,
  input  logic [DW-1:0] mem_read_data
);

  state_t        state;
  state_t        state_d;

  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [3:0]    be_q;
  logic          id_q;
  logic          last_grant;
  logic [DW-1:0] merge_q;

  logic          eff0;
  logic          eff1;
  logic          grant;
  logic          grant_id;
  logic          done;
  logic          rd_done;
  logic          wr_raw;
  logic [DW-1:0] merged;

  // Partial-store data: new bytes where enabled, current memory bytes elsewhere.
  dmem_byte_merge #(.DW(DW)) u_merge (
    .old_word (mem_read_data),
    .new_word (wdata_q),
    .be       (be_q),
    .merged   (merged)
  );

  // Next-state, grant selection and access completion decode.
  always_comb begin
    state_d  = state;
    grant    = 1'b0;
    grant_id = 1'b0;
    done     = 1'b0;
    // A port is masked in its own ack cycle so a held req is not re-granted.
    eff0     = req0 & ~ack0;
    eff1     = req1 & ~ack1;
    case (state)
      IDLE: begin
        if (eff0 && eff1) begin
          grant    = 1'b1;
          grant_id = ~last_grant;
        end else if (eff0) begin
          grant    = 1'b1;
          grant_id = 1'b0;
        end else if (eff1) begin
          grant    = 1'b1;
          grant_id = 1'b1;
        end
        if (grant) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (we_q && (be_q != BE_FULL) && (be_q != BE_NONE)) begin
          state_d = MERGE_WR;
        end else begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      MERGE_WR: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Memory-side decode; the write is gated by reset so an aborted merge never lands.
  always_comb begin
    rd_done        = (state == ACCESS) && !we_q;
    wr_raw         = ((state == ACCESS) && we_q && (be_q == BE_FULL)) || (state == MERGE_WR);
    mem_write      = wr_raw & rst_n;
    mem_address    = addr_q;
    mem_write_data = (state == MERGE_WR) ? merge_q : wdata_q;
    busy           = (state != IDLE);
  end

  // State register, request latches, merge buffer, read data and ack pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
      merge_q    <= '0;
      rdata      <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
    end else begin
      state <= state_d;
      ack0  <= done & ~id_q;
      ack1  <= done & id_q;
      if (grant) begin
        id_q       <= grant_id;
        last_grant <= grant_id;
        we_q       <= grant_id ? we1 : we0;
        addr_q     <= grant_id ? addr1 : addr0;
        wdata_q    <= grant_id ? wdata1 : wdata0;
        be_q       <= grant_id ? be1 : be0;
      end
      if (rd_done) begin
        rdata <= mem_read_data;
      end
      if (state == ACCESS) begin
        merge_q <= merged;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural data memory.
// Latency: checks ack cycle counts measured from the req-sampling edge.
// Backpressure: requesters hold req until ack, as the arbiter expects.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0, we0, req1, we1;
  logic [31:0] addr0, wdata0, addr1, wdata1;
  logic [3:0]  be0, be1;
  logic        ack0, ack1, busy, mem_write;
  logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [0:63];

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter #(.DW(32), .AW(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0           (req0),
    .we0            (we0),
    .addr0          (addr0),
    .wdata0         (wdata0),
    .be0            (be0),
    .req1           (req1),
    .we1            (we1),
    .addr1          (addr1),
    .wdata1         (wdata1),
    .be1            (be1),
    .ack0           (ack0),
    .ack1           (ack1),
    .rdata          (rdata),
    .busy           (busy),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write on posedge, word index from address[7:2].
  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[7:2]] <= mem_write_data;
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One access on one port; returns ack cycle (99 on timeout) and count of mem_write cycles.
  task automatic do_access(input bit port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           output int lat, output int wr_cycles);
    bit got;
    got = 1'b0;
    if (port == 1'b0) begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; be0 = be;
    end else begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; be1 = be;
    end
    lat = 0;
    wr_cycles = 0;
    if (mem_write) wr_cycles++;
    while (lat < 20 && !got) begin
      @(posedge clk);
      #1;
      lat++;
      if ((port == 1'b0 && ack0) || (port == 1'b1 && ack1)) got = 1'b1;
      else if (mem_write) wr_cycles++;
    end
    if (!got) lat = 99;
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++; if (ack0 !== 1'b0)       begin n_err++; $display("FAIL reset_ack0 got=%b exp=0", ack0); end
    n_cmp++; if (ack1 !== 1'b0)       begin n_err++; $display("FAIL reset_ack1 got=%b exp=0", ack1); end
    n_cmp++; if (rdata !== 32'h0)     begin n_err++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (mem_write !== 1'b0)  begin n_err++; $display("FAIL reset_mem_write got=%b exp=0", mem_write); end
    n_cmp++; if (mem_address !== 32'h0) begin n_err++; $display("FAIL reset_mem_address got=%h exp=0", mem_address); end
  endtask

  task automatic test_full_write_read();
    int lat, wr;
    do_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, wr);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL fullwr_latency got=%0d exp=2", lat); end
    n_cmp++; if (wr !== 1)  begin n_err++; $display("FAIL fullwr_write_cycles got=%0d exp=1", wr); end
    n_cmp++; if (mem[4] !== 32'hDEADBEEF) begin n_err++; $display("FAIL fullwr_mem got=%h exp=deadbeef", mem[4]); end
    do_access(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, wr);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL read_latency got=%0d exp=2", lat); end
    n_cmp++; if (wr !== 0)  begin n_err++; $display("FAIL read_write_cycles got=%0d exp=0", wr); end
    n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_rdata got=%h exp=deadbeef", rdata); end
  endtask

  task automatic test_partial_write();
    int lat, wr;
    do_access(1'b1, 1'b1, 32'h20, 32'h11223344, 4'hF, lat, wr);
    do_access(1'b1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, lat, wr);
    n_cmp++; if (lat !== 3) begin n_err++; $display("FAIL partial_latency got=%0d exp=3", lat); end
    n_cmp++; if (wr !== 1)  begin n_err++; $display("FAIL partial_write_cycles got=%0d exp=1", wr); end
    n_cmp++; if (mem[8] !== 32'h11BB33DD) begin n_err++; $display("FAIL partial_mem got=%h exp=11bb33dd", mem[8]); end
    // Misaligned address reads the same word.
    do_access(1'b1, 1'b0, 32'h23, 32'h0, 4'h0, lat, wr);
    n_cmp++; if (rdata !== 32'h11BB33DD) begin n_err++; $display("FAIL partial_readback got=%h exp=11bb33dd", rdata); end
  endtask

  task automatic test_empty_write();
    int lat, wr;
    do_access(1'b1, 1'b1, 32'h30, 32'h55AA55AA, 4'hF, lat, wr);
    do_access(1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, 4'h0, lat, wr);
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL empty_latency got=%0d exp=2", lat); end
    n_cmp++; if (wr !== 0)  begin n_err++; $display("FAIL empty_write_cycles got=%0d exp=0", wr); end
    n_cmp++; if (mem[12] !== 32'h55AA55AA) begin n_err++; $display("FAIL empty_mem got=%h exp=55aa55aa", mem[12]); end
  endtask

  task automatic test_round_robin();
    int lat, wr, n;
    int ids [4];
    int tms [4];
    logic [31:0] dat [4];
    int exp_id [4];
    int exp_tm [4];
    logic [31:0] exp_dat [4];
    exp_id = '{0, 1, 0, 1};
    exp_tm = '{2, 4, 6, 8};
    exp_dat = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hA0A0A0A0, 32'hB1B1B1B1};
    do_access(1'b1, 1'b1, 32'h0, 32'hA0A0A0A0, 4'hF, lat, wr);
    do_access(1'b1, 1'b1, 32'h4, 32'hB1B1B1B1, 4'hF, lat, wr);
    apply_reset();
    n = 0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    for (int c = 1; c <= 20 && n < 4; c++) begin
      @(posedge clk);
      #1;
      n_cmp++; if ((ack0 & ack1) !== 1'b0) begin n_err++; $display("FAIL rr_ack_overlap cycle=%0d ack0=%b ack1=%b", c, ack0, ack1); end
      if (ack0) begin ids[n] = 0; tms[n] = c; dat[n] = rdata; n++; end
      else if (ack1) begin ids[n] = 1; tms[n] = c; dat[n] = rdata; n++; end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL rr_ack_count got=%0d exp=4", n); end
    for (int k = 0; k < n; k++) begin
      n_cmp++; if (ids[k] !== exp_id[k]) begin n_err++; $display("FAIL rr_grant_id[%0d] got=%0d exp=%0d", k, ids[k], exp_id[k]); end
      n_cmp++; if (tms[k] !== exp_tm[k]) begin n_err++; $display("FAIL rr_ack_cycle[%0d] got=%0d exp=%0d", k, tms[k], exp_tm[k]); end
      n_cmp++; if (dat[k] !== exp_dat[k]) begin n_err++; $display("FAIL rr_rdata[%0d] got=%h exp=%h", k, dat[k], exp_dat[k]); end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_bubble();
    int n;
    int ids [4];
    int tms [4];
    int exp_id [4];
    int exp_tm [4];
    exp_id = '{1, 1, 0, 1};
    exp_tm = '{2, 5, 7, 9};
    apply_reset();
    n = 0;
    req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4;
    we0 = 1'b0; addr0 = 32'h0;
    for (int c = 1; c <= 20 && n < 4; c++) begin
      @(posedge clk);
      #1;
      n_cmp++; if ((ack0 & ack1) !== 1'b0) begin n_err++; $display("FAIL bubble_ack_overlap cycle=%0d", c); end
      if (ack0) begin ids[n] = 0; tms[n] = c; n++; req0 = 1'b0; end
      else if (ack1) begin ids[n] = 1; tms[n] = c; n++; end
      if (c == 4) req0 = 1'b1;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    n_cmp++; if (n !== 4) begin n_err++; $display("FAIL bubble_ack_count got=%0d exp=4", n); end
    for (int k = 0; k < n; k++) begin
      n_cmp++; if (ids[k] !== exp_id[k]) begin n_err++; $display("FAIL bubble_grant_id[%0d] got=%0d exp=%0d", k, ids[k], exp_id[k]); end
      n_cmp++; if (tms[k] !== exp_tm[k]) begin n_err++; $display("FAIL bubble_ack_cycle[%0d] got=%0d exp=%0d", k, tms[k], exp_tm[k]); end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_merge();
    int lat, wr;
    do_access(1'b1, 1'b1, 32'h40, 32'h01020304, 4'hF, lat, wr);
    do_access(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, lat, wr);
    n_cmp++; if (rdata !== 32'h01020304) begin n_err++; $display("FAIL abort_pre_rdata got=%h exp=01020304", rdata); end
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'hFFFFFFFF; be0 = 4'b0011;
    @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_access got=%b exp=1", busy); end
    @(posedge clk);
    #1;
    n_cmp++; if (mem_write !== 1'b1) begin n_err++; $display("FAIL abort_merge_state got=%b exp=1", mem_write); end
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL abort_write_gated got=%b exp=0", mem_write); end
    @(posedge clk);
    #1;
    n_cmp++; if (ack0 !== 1'b0)      begin n_err++; $display("FAIL abort_ack0 got=%b exp=0", ack0); end
    n_cmp++; if (ack1 !== 1'b0)      begin n_err++; $display("FAIL abort_ack1 got=%b exp=0", ack1); end
    n_cmp++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL abort_mem_write got=%b exp=0", mem_write); end
    n_cmp++; if (busy !== 1'b0)      begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
    n_cmp++; if (rdata !== 32'h0)    begin n_err++; $display("FAIL abort_rdata got=%h exp=0", rdata); end
    n_cmp++; if (mem[16] !== 32'h01020304) begin n_err++; $display("FAIL abort_mem got=%h exp=01020304", mem[16]); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++; if (ack0 !== 1'b0) begin n_err++; $display("FAIL abort_late_ack0 got=%b exp=0", ack0); end
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_partial_write();
    test_empty_write();
    test_round_robin();
    test_bubble();
    test_reset_mid_merge();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
